// File: rtl/switch_scan_ctrl.sv
// Switch scanner: syncs and debounces the board switches, then writes the stable word
// into dmem on idle core write cycles. Optional change counter: define SWSCAN_CNT_EN.
module switch_scan_ctrl #(
    parameter int          NSW        = 5,
    parameter int          DEB_CYCLES = 16,
    parameter logic [31:0] SW_ADDR    = 32'h0000_0080
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSW-1:0]  sw,
    input  logic            core_we,
    input  logic [31:0]     core_adr,
    input  logic [31:0]     core_wd,
    output logic            mem_we,
    output logic [31:0]     mem_adr,
    output logic [31:0]     mem_wd,
    output logic [NSW-1:0]  sw_state,
    output logic            pend,
    output logic [7:0]      busy_cycles
);

    localparam int            CW      = $clog2(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    logic [NSW-1:0] sync1;
    logic [NSW-1:0] sync2;
    logic [NSW-1:0] stable;
    logic [NSW-1:0] flip;
    logic [CW-1:0]  deb_cnt [NSW];
    logic           change;

    state_t         state;
    state_t         state_next;
    logic [NSW-1:0] snapshot;
    logic [NSW-1:0] snap_next;
    logic           own;
    logic           busy_inc;
    logic [7:0]     busy;
    logic [31:0]    eng_wd;

    // Two-flop synchronizer per switch bit.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= sw;
            sync2 <= sync1;
        end
    end

    // A bit is accepted on the DEB_CYCLES-th consecutive cycle it differs from stable.
    always_comb begin
        flip = '0;
        for (int i = 0; i < NSW; i++) begin
            flip[i] = (sync2[i] != stable[i]) && (deb_cnt[i] == CNT_MAX);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            stable <= '0;
            change <= 1'b0;
            for (int i = 0; i < NSW; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            stable <= stable ^ flip;
            change <= |flip;
            for (int i = 0; i < NSW; i++) begin
                if ((sync2[i] == stable[i]) || flip[i]) begin
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + CW'(1);
                end
            end
        end
    end

    assign sw_state = stable;

`ifdef SWSCAN_CNT_EN
    // Wrapping count of accepted changes, carried in the upper byte of the engine write.
    logic [7:0] chg_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            chg_cnt <= 8'd0;
        end else if (change) begin
            chg_cnt <= chg_cnt + 8'd1;
        end
    end

    always_comb begin
        eng_wd       = 32'(snapshot);
        eng_wd[15:8] = chg_cnt;
    end
`else
    assign eng_wd = 32'(snapshot);
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            snapshot <= '0;
            busy     <= 8'd0;
        end else begin
            state    <= state_next;
            snapshot <= snap_next;
            if (busy_inc && (busy != 8'hFF)) begin
                busy <= busy + 8'd1;
            end
        end
    end

    // The engine only takes the port in PEND on a cycle the core is not writing;
    // a change arriving meanwhile just refreshes the snapshot (latest word wins).
    always_comb begin
        state_next = state;
        snap_next  = snapshot;
        own        = 1'b0;
        busy_inc   = 1'b0;
        unique case (state)
            IDLE: begin
                if (change) begin
                    state_next = PEND;
                    snap_next  = stable;
                end
            end
            PEND: begin
                if (!core_we) begin
                    own = 1'b1;
                    if (change) begin
                        snap_next = stable;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    busy_inc = 1'b1;
                    if (change) begin
                        snap_next = stable;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        mem_we  = core_we;
        mem_adr = core_adr;
        mem_wd  = core_wd;
        if (!reset) begin
            mem_we = 1'b0;
        end else if (own) begin
            mem_we  = 1'b1;
            mem_adr = SW_ADDR;
            mem_wd  = eng_wd;
        end
    end

    assign pend        = (state == PEND);
    assign busy_cycles = busy;

endmodule

// File: tb/tb_switch_scan_ctrl.sv
// Bench for switch_scan_ctrl: directed multi-cycle sequences plus a pass-through vector table.
module tb_switch_scan_ctrl;

    localparam int NSW = 5;
`ifdef SWSCAN_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [NSW-1:0] sw = '0;
    logic           core_we = 1'b0;
    logic [31:0]    core_adr = '0;
    logic [31:0]    core_wd = '0;
    logic           mem_we;
    logic [31:0]    mem_adr;
    logic [31:0]    mem_wd;
    logic [NSW-1:0] sw_state;
    logic           pend;
    logic [7:0]     busy_cycles;

    int errors = 0;
    int checks = 0;
    int exp_cnt = 0;

    typedef struct {
        logic        rst;
        logic        we;
        logic [31:0] adr;
        logic [31:0] wd;
        logic        exp_we;
    } vec_t;

    vec_t vecs [6];

    switch_scan_ctrl #(
        .NSW(NSW),
        .DEB_CYCLES(16),
        .SW_ADDR(32'h0000_0080)
    ) dut (
        .clk(clk),
        .reset(reset),
        .sw(sw),
        .core_we(core_we),
        .core_adr(core_adr),
        .core_wd(core_wd),
        .mem_we(mem_we),
        .mem_adr(mem_adr),
        .mem_wd(mem_wd),
        .sw_state(sw_state),
        .pend(pend),
        .busy_cycles(busy_cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h required 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    function automatic logic [31:0] eng_wd(input logic [NSW-1:0] snap);
        logic [31:0] w;
        w = 32'(snap);
        if (CNT_EN) w[15:8] = exp_cnt[7:0];
        return w;
    endfunction

    task automatic check_pass(input string name);
        check({name, "_we"}, 32'(mem_we), 32'(core_we));
        check({name, "_adr"}, mem_adr, core_adr);
        check({name, "_wd"}, mem_wd, core_wd);
    endtask

    task automatic check_eng(input string name, input logic [NSW-1:0] snap);
        check({name, "_we"}, 32'(mem_we), 32'd1);
        check({name, "_adr"}, mem_adr, 32'h0000_0080);
        check({name, "_wd"}, mem_wd, eng_wd(snap));
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 1'b1};
        vecs[1] = '{1'b1, 1'b0, 32'h0000_0080, 32'h1234_5678, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 32'h0000_0080, 32'hFFFF_FFFF, 1'b1};
        vecs[3] = '{1'b0, 1'b1, 32'h0000_0040, 32'hA5A5_A5A5, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 32'hFFFF_FFFC, 32'h0000_001F, 1'b1};

        // Reset held low with all switches on and the core trying to write.
        reset = 1'b0; sw = 5'b11111;
        core_we = 1'b1; core_adr = 32'h44; core_wd = 32'h99;
        for (int t = 1; t <= 3; t++) begin
            tick(); settle();
            check("rst_we", 32'(mem_we), 32'd0);
            check("rst_adr", mem_adr, 32'h44);
            check("rst_wd", mem_wd, 32'h99);
            check("rst_sw_state", 32'(sw_state), 32'd0);
            check("rst_pend", 32'(pend), 32'd0);
            check("rst_busy", 32'(busy_cycles), 32'd0);
        end

        // Release: 11111 accepted after 2+16 edges, engine write one cycle later.
        reset = 1'b1; core_we = 1'b0; core_adr = 32'h10; core_wd = 32'h0;
        for (int t = 1; t <= 20; t++) begin
            tick();
            if (t == 18) exp_cnt++;
            settle();
            check("rel_sw_state", 32'(sw_state), (t >= 18) ? 32'h1F : 32'h0);
            check("rel_pend", 32'(pend), 32'(t == 19));
            if (t == 19) check_eng("rel_eng", 5'b11111);
            else check("rel_we", 32'(mem_we), 32'd0);
        end

        // 10-cycle glitch on sw[0] must be filtered; core traffic passes untouched.
        sw = 5'b11110;
        for (int t = 1; t <= 40; t++) begin
            tick();
            if (t == 10) sw = 5'b11111;
            core_we = 1'($urandom_range(0, 1));
            core_adr = $urandom;
            core_wd = $urandom;
            settle();
            check("glitch_sw_state", 32'(sw_state), 32'h1F);
            check("glitch_pend", 32'(pend), 32'd0);
            check_pass("glitch");
        end

        // Steady 00101 with an idle core: exactly one engine write.
        core_we = 1'b0; core_adr = 32'h200; core_wd = 32'h5555; sw = 5'b00101;
        for (int t = 1; t <= 50; t++) begin
            tick();
            if (t == 18) exp_cnt++;
            settle();
            check("idle_sw_state", 32'(sw_state), (t >= 18) ? 32'h5 : 32'h1F);
            check("idle_pend", 32'(pend), 32'(t == 19));
            if (t == 19) check_eng("idle_eng", 5'b00101);
            else check("idle_we", 32'(mem_we), 32'd0);
        end

        // Change lands while the core writes for 4 PEND cycles (one to SW_ADDR).
        sw = 5'b00111;
        for (int t = 1; t <= 30; t++) begin
            tick();
            core_we = 1'(t >= 17 && t <= 22);
            core_adr = (t == 20) ? 32'h80 : 32'h100 + 32'(t);
            core_wd = 32'hC0DE_0000 + 32'(t);
            if (t == 18) exp_cnt++;
            settle();
            check("busy_sw_state", 32'(sw_state), (t >= 18) ? 32'h7 : 32'h5);
            check("busy_pend", 32'(pend), 32'(t >= 19 && t <= 23));
            if (t == 23) begin
                check_eng("busy_eng", 5'b00111);
                check("busy_count4", 32'(busy_cycles), 32'd4);
            end else begin
                check_pass("busy_core");
            end
        end

        // Coalescing: 00100 then back to 00111 while PEND; one write of the latest word.
        sw = 5'b00100;
        for (int t = 1; t <= 50; t++) begin
            tick();
            if (t == 19) sw = 5'b00111;
            core_we = 1'(t <= 37);
            core_adr = 32'h300 + 32'(t);
            core_wd = ~32'(t);
            if (t == 18 || t == 37) exp_cnt++;
            settle();
            check("coal_sw_state", 32'(sw_state), (t >= 18 && t < 37) ? 32'h4 : 32'h7);
            check("coal_pend", 32'(pend), 32'(t >= 19 && t <= 38));
            if (t == 38) begin
                check_eng("coal_eng", 5'b00111);
                check("coal_busy", 32'(busy_cycles), 32'd23);
            end else begin
                check_pass("coal_core");
            end
        end

        // Long core burst in PEND: busy_cycles saturates at 255.
        sw = 5'b00110;
        for (int t = 1; t <= 260; t++) begin
            tick();
            core_we = 1'b1; core_adr = 32'h400; core_wd = 32'h1;
            if (t == 18) exp_cnt++;
            settle();
            if (t == 250) check("sat_busy_254", 32'(busy_cycles), 32'd254);
            if (t == 251) check("sat_busy_255", 32'(busy_cycles), 32'd255);
            if (t == 260) begin
                check("sat_busy_hold", 32'(busy_cycles), 32'd255);
                check("sat_pend", 32'(pend), 32'd1);
            end
        end

        // Reset mid-PEND drops the pending write.
        reset = 1'b0; sw = '0; core_we = 1'b1; core_adr = 32'h80; core_wd = 32'hFFFF;
        settle();
        check("midrst_we_forced", 32'(mem_we), 32'd0);
        check("midrst_adr", mem_adr, 32'h80);
        check("midrst_pend_before", 32'(pend), 32'd1);
        tick(); settle();
        exp_cnt = 0;
        check("midrst_pend", 32'(pend), 32'd0);
        check("midrst_busy", 32'(busy_cycles), 32'd0);
        check("midrst_sw_state", 32'(sw_state), 32'd0);
        check("midrst_we", 32'(mem_we), 32'd0);
        reset = 1'b1; core_we = 1'b0;
        for (int t = 1; t <= 100; t++) begin
            tick(); settle();
            check("post_rst_we", 32'(mem_we), 32'd0);
            check("post_rst_pend", 32'(pend), 32'd0);
        end

        // Pass-through / reset-forcing vectors with the engine idle.
        for (int i = 0; i < 6; i++) begin
            tick();
            reset = vecs[i].rst;
            core_we = vecs[i].we;
            core_adr = vecs[i].adr;
            core_wd = vecs[i].wd;
            settle();
            check("vec_we", 32'(mem_we), 32'(vecs[i].exp_we));
            check("vec_adr", mem_adr, vecs[i].adr);
            check("vec_wd", mem_wd, vecs[i].wd);
            check("vec_pend", 32'(pend), 32'd0);
        end
        reset = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
